// File: rtl/intersection_scheduler_if.sv
// intersection_scheduler_if
//   Groups the road-side signals of the intersection scheduler.
//   master : sensor/stimulus side, drives T_A, T_B, preempt and observes lamps.
//   slave  : scheduler side, consumes sensor inputs and drives lamps/status.
//   Signals:
//     T_A, T_B  vehicle present on street A / B (level, synchronous to clk)
//     preempt   emergency request, parks both roads at red
//     L_A, L_B  lamp codes: 00 green, 01 yellow, 11 red
//     phase     current scheduler state code
//     req_A/B   latched pending requests
//     tick      one-cycle prescaler pulse
interface intersection_scheduler_if;
  logic       T_A;
  logic       T_B;
  logic       preempt;
  logic [1:0] L_A;
  logic [1:0] L_B;
  logic [2:0] phase;
  logic       req_A;
  logic       req_B;
  logic       tick;

  modport master (
    output T_A, T_B, preempt,
    input  L_A, L_B, phase, req_A, req_B, tick
  );

  modport slave (
    input  T_A, T_B, preempt,
    output L_A, L_B, phase, req_A, req_B, tick
  );
endinterface

// File: rtl/intersection_scheduler.sv
// intersection_scheduler
//   Timed two-road intersection controller. Latches vehicle requests, enforces
//   min/max green, yellow and all-red clearance measured in prescaler ticks,
//   and supports a preempt input that parks both roads at red.
//   Ports:
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      intersection_scheduler_if.slave (sensors in, lamps/status out)
//   Parameters (all in ticks except TICK_DIV, which is in clk cycles):
//     TICK_DIV, MIN_GREEN, MAX_GREEN, YELLOW, ALL_RED
module intersection_scheduler #(
  parameter int unsigned TICK_DIV  = 10,
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned MAX_GREEN = 12,
  parameter int unsigned YELLOW    = 2,
  parameter int unsigned ALL_RED   = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  intersection_scheduler_if.slave   bus
);

  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);
  localparam logic [7:0] MIN_G     = 8'(MIN_GREEN);
  localparam logic [7:0] MAX_G     = 8'(MAX_GREEN);
  localparam logic [7:0] YEL_T     = 8'(YELLOW);
  localparam logic [7:0] AR_T      = 8'(ALL_RED);

  localparam logic [1:0] LAMP_G = 2'b00;
  localparam logic [1:0] LAMP_Y = 2'b01;
  localparam logic [1:0] LAMP_R = 2'b11;

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    AR_AB = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    AR_BA = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pre_q, pre_d;
  logic [7:0] cnt_q, cnt_d;
  logic       req_a_q, req_a_d;
  logic       req_b_q, req_b_d;
  logic [1:0] la_q, la_d;
  logic [1:0] lb_q, lb_d;

  logic       tick_w;
  logic [7:0] n_w;
  logic       exit_w;
  logic       bad_w;
  state_t     nxt_w;

  function automatic logic [1:0] lamp_a(input state_t s);
    case (s)
      A_GRN:   lamp_a = LAMP_G;
      A_YEL:   lamp_a = LAMP_Y;
      default: lamp_a = LAMP_R;
    endcase
  endfunction

  function automatic logic [1:0] lamp_b(input state_t s);
    case (s)
      B_GRN:   lamp_b = LAMP_G;
      B_YEL:   lamp_b = LAMP_Y;
      default: lamp_b = LAMP_R;
    endcase
  endfunction

  always_comb begin
    tick_w = (pre_q == TICK_LAST);
    pre_d  = tick_w ? 8'd0 : pre_q + 8'd1;

    // Dwell count including the tick being processed now; saturates so a
    // resting green never wraps and re-arms the min-green check.
    n_w = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

    nxt_w  = state_q;
    exit_w = 1'b0;
    bad_w  = 1'b0;
    case (state_q)
      A_GRN: begin
        nxt_w  = A_YEL;
        exit_w = bus.preempt ||
                 ((n_w >= MIN_G) && req_b_q && (!bus.T_A || (n_w >= MAX_G)));
      end
      A_YEL: begin
        nxt_w  = AR_AB;
        exit_w = (n_w >= YEL_T);
      end
      AR_AB: begin
        nxt_w  = B_GRN;
        exit_w = (n_w >= AR_T) && !bus.preempt;
      end
      B_GRN: begin
        nxt_w  = B_YEL;
        exit_w = bus.preempt ||
                 ((n_w >= MIN_G) && req_a_q && (!bus.T_B || (n_w >= MAX_G)));
      end
      B_YEL: begin
        nxt_w  = AR_BA;
        exit_w = (n_w >= YEL_T);
      end
      AR_BA: begin
        nxt_w  = A_GRN;
        exit_w = (n_w >= AR_T) && !bus.preempt;
      end
      default: begin
        // Unreachable codes recover to a safe all-red state without waiting
        // for a tick.
        nxt_w  = AR_AB;
        exit_w = 1'b1;
        bad_w  = 1'b1;
      end
    endcase

    state_d = state_q;
    cnt_d   = cnt_q;
    if (bad_w) begin
      state_d = nxt_w;
      cnt_d   = 8'd0;
    end else if (tick_w) begin
      if (exit_w) begin
        state_d = nxt_w;
        cnt_d   = 8'd0;
      end else begin
        cnt_d = n_w;
      end
    end

    // Entering a green clears that road's request even if its sensor is
    // asserted on the same edge.
    if ((state_d == A_GRN) && (state_q != A_GRN))
      req_a_d = 1'b0;
    else
      req_a_d = req_a_q | (bus.T_A && (state_q != A_GRN));

    if ((state_d == B_GRN) && (state_q != B_GRN))
      req_b_d = 1'b0;
    else
      req_b_d = req_b_q | (bus.T_B && (state_q != B_GRN));

    la_d = lamp_a(state_d);
    lb_d = lamp_b(state_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= A_GRN;
      pre_q   <= 8'd0;
      cnt_q   <= 8'd0;
      req_a_q <= 1'b0;
      req_b_q <= 1'b0;
      la_q    <= LAMP_G;
      lb_q    <= LAMP_R;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      req_a_q <= req_a_d;
      req_b_q <= req_b_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
    end
  end

  assign bus.L_A   = la_q;
  assign bus.L_B   = lb_q;
  assign bus.phase = state_q;
  assign bus.req_A = req_a_q;
  assign bus.req_B = req_b_q;
  assign bus.tick  = tick_w;

endmodule

// File: doc/intersection_scheduler.md
# intersection_scheduler

Timed two-road intersection controller that shares the crossing between street A and street B. Latches vehicle requests from the road sensors, enforces minimum/maximum green, yellow and all-red clearance times from a clock prescaler, and supports a preempt input that forces both roads to red. Drives the lamp encodings directly (green 00, yellow 01, red 11) and sits between the road sensors and the lamp drivers.

## Interface
- TICK_DIV, 10: clk cycles per timing tick, 1..255
- MIN_GREEN, 4: minimum green dwell in ticks, 1..255
- MAX_GREEN, 12: maximum green dwell in ticks while the other road waits, MIN_GREEN..255
- YELLOW, 2: yellow dwell in ticks, 1..255
- ALL_RED, 1: all-red clearance in ticks, 1..255
- clk  in  1  system clock, all state updates on the rising edge
- reset_n  in  1  reset, asynchronous, active-low
- T_A  in  1  street A vehicle present (level, synchronous to clk)
- T_B  in  1  street B vehicle present (level)
- preempt  in  1  emergency request: drive both roads to red and hold
- L_A  out  2  street A lamp: 00 green, 01 yellow, 11 red
- L_B  out  2  street B lamp, same encoding
- phase  out  3  current state encoding
- req_A  out  1  latched pending request for street A
- req_B  out  1  latched pending request for street B
- tick  out  1  one-cycle prescaler pulse

## Operation
- States and phase codes: A_GRN 0, A_YEL 1, AR_AB 2, B_GRN 3, B_YEL 4, AR_BA 5. Codes 6/7 unreachable; if decoded, next edge goes to AR_AB.
- Lamps (Moore, decoded from state): A_GRN 00/11, A_YEL 01/11, AR_AB 11/11, B_GRN 11/00, B_YEL 11/01, AR_BA 11/11.
- Prescaler pre counts 0..TICK_DIV-1 freely; tick = (pre == TICK_DIV-1). TICK_DIV=1 gives tick constantly high.
- Dwell counter cnt (8 bit) = completed ticks in current state. On tick: n = cnt+1 (saturate 255); if exit condition true on n, transition and cnt <= 0, else cnt <= n. No state change without tick.
- Request latches: req_A sets on any clk where T_A=1 and state != A_GRN; clears on the edge that enters A_GRN (clear wins over set). req_B symmetric with B_GRN.
- Exit conditions (evaluated on tick, n as above):
  - A_GRN -> A_YEL: preempt, or (n >= MIN_GREEN and req_B and (!T_A or n >= MAX_GREEN)). No req_B: rest in A_GRN indefinitely.
  - A_YEL -> AR_AB: n >= YELLOW (preempt does not shorten).
  - AR_AB -> B_GRN: n >= ALL_RED and !preempt.
  - B_GRN/B_YEL/AR_BA: mirror of the above with A and B swapped, AR_BA -> A_GRN.
- Preempt held: scheduler parks in the all-red state after the current yellow; on release, next eligible tick enters the opposite road's green.
- cnt saturation at 255 keeps resting green stable.

## Timing
- Reset (async assert): state A_GRN, L_A=00, L_B=11, phase=0, cnt=0, pre=0, tick=0, req_A=0, req_B=0. Applies immediately, mid-phase included; no yellow is emitted on reset.
- After reset release the first tick is on the TICK_DIV-th rising edge; all state entries are tick-aligned, so a phase of k ticks lasts exactly k*TICK_DIV cycles.
- Request to lamp change latency: lamps change on the tick edge where the exit condition holds, no further pipeline.
- A 1-cycle T_B pulse during A_GRN is sufficient to be served.

## Test plan
- Reset, T_A=T_B=0, 500 cycles -> L_A=00, L_B=11, phase=0 throughout, req_A=req_B=0, tick every 10 cycles.
- T_A=0, single-cycle T_B pulse at cycle 3 -> req_B=1; at 4th tick A_YEL (L_A=01) for 20 cycles, AR_AB 10 cycles (11/11), then B_GRN (L_B=00) with req_B=0.
- T_A=T_B=1 constant -> A green 120 cycles (MAX_GREEN), 20 yellow, 10 all-red, B green 120 cycles, repeating.
- preempt=1 at tick 2 of A_GRN (before MIN_GREEN) -> A_YEL on next tick, AR_AB held while preempt high; preempt low -> B_GRN at next tick only if req_B, else still B_GRN per AR_AB rule (entered after ALL_RED).
- reset_n low for 3 cycles mid B_YEL -> outputs immediately 00/11, phase 0, requests cleared, prescaler restarts.
- T_A asserted in A_GRN only -> req_A stays 0; T_A asserted during AR_BA on the entering edge -> req_A ends 0.
